// File: rtl/fifo_pkg.sv
// Shared types for the FIFO drain path: data width, UART transmitter state
// encoding and the even-parity helper.
package fifo_pkg;

    localparam int DATA_W = 8;

    // PARITY is always present so the encoding does not move with the build option.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        CAPTURE = 3'd2,
        START   = 3'd3,
        DATA    = 3'd4,
        PARITY  = 3'd5,
        STOP    = 3'd6
    } tx_state_e;

    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT clocks per serial bit and flags the
// last clock of each bit. Held at zero while clr is high.
module fifo_uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             last_s;

    // Wrapping clock-within-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (last_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + ONE_CNT;
        end
    end

    // Last-cycle decode, suppressed while the counter is held.
    always_comb begin
        last_s = 1'b0;
        if (cnt_r == LAST_CNT) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    assign bit_end = last_s && !clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as an async 8N1 frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              pop_out,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [7:0]        tx_count
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] ONE_BIT  = BIT_W'(1);

    tx_state_e         state_r;
    logic [DATA_W-1:0] shift_r;
    logic [BIT_W-1:0]  bit_idx_r;
    logic [BIT_W-1:0]  bit_nxt_s;
    logic              tx_r;
    logic              pop_r;
    logic              busy_r;
    logic              done_r;
    logic [7:0]        count_r;
    logic              clr_s;
    logic              bit_end_s;

    // Bit timer only runs once the frame proper (start bit onward) begins.
    always_comb begin
        clr_s     = 1'b0;
        bit_nxt_s = bit_idx_r + ONE_BIT;
        case (state_r)
            IDLE, POP, CAPTURE: clr_s = 1'b1;
            default:            clr_s = 1'b0;
        endcase
    end

    fifo_uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (clr_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencer; every output is loaded alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            shift_r   <= {DATA_W{1'b0}};
            bit_idx_r <= {BIT_W{1'b0}};
            tx_r      <= 1'b1;
            pop_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            count_r   <= 8'd0;
        end else begin
            pop_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (en && !empty) begin
                        state_r <= POP;
                        pop_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                POP: begin
                    state_r <= CAPTURE;
                end
                CAPTURE: begin
                    shift_r <= fifo_dout;
                    tx_r    <= 1'b0;
                    state_r <= START;
                end
                START: begin
                    if (bit_end_s) begin
                        bit_idx_r <= {BIT_W{1'b0}};
                        tx_r      <= shift_r[0];
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_r    <= even_parity(shift_r);
                            state_r <= PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_nxt_s;
                            tx_r      <= shift_r[bit_nxt_s];
                        end
                    end
                end
                PARITY: begin
                    // Also the recovery path if this state is reached without the option.
                    if (bit_end_s) begin
                        tx_r    <= 1'b1;
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        count_r <= count_r + 8'd1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign pop_out  = pop_r;
    assign tx       = tx_r;
    assign busy     = busy_r;
    assign tx_done  = done_r;
    assign tx_count = count_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model plus per-cycle output log,
// frames compared against a bit-list reference of the serial format.
module tb_fifo_uart_tx;

    localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Cycles from the pop cycle to the tx_done cycle; byte period is L+1.
    localparam int L = NBITS * C + 2;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       pop_out, tx, busy, tx_done;
    logic [7:0] tx_count;

    logic [7:0] q[$];
    logic tx_log   [MAXC];
    logic pop_log  [MAXC];
    logic done_log [MAXC];
    logic busy_log [MAXC];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int underruns = 0;
    int exp_count = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .empty     (empty),
        .fifo_dout (fifo_dout),
        .pop_out   (pop_out),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;

    // FIFO model and per-cycle log, both on the falling edge.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            tx_log[cyc]   = tx;
            pop_log[cyc]  = pop_out;
            done_log[cyc] = tx_done;
            busy_log[cyc] = busy;
        end
        if (pop_out === 1'b1) begin
            if (q.size() > 0) fifo_dout = q.pop_front();
            else underruns++;
        end
        empty = (q.size() == 0);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level o cycles after the pop cycle.
    function automatic logic exp_tx(input int o, input logic [7:0] b);
        int k;
        if (o < 2) return 1'b1;
        k = (o - 2) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // First offset after pop cycle p where the log departs from the reference, or -1.
    function automatic int frame_mismatch_at(input int p, input logic [7:0] b);
        for (int o = 1; o <= L; o++) begin
            if (p < 0 || p + o >= MAXC || p + o >= cyc) return o;
            if (tx_log[p+o] !== exp_tx(o, b)) return o;
            if (done_log[p+o] !== (o == L)) return o;
            if (busy_log[p+o] !== (o < L)) return o;
            if (pop_log[p+o] !== 1'b0) return o;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        empty = 1'b0;
    endtask

    task automatic wait_pop(output int p, input int budget);
        p = -1;
        for (int i = 0; i < budget; i++) begin
            if (pop_out === 1'b1) begin
                p = cyc;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [7:0] b;
        int p, m;
        b = 8'($urandom);
        push(b);
        en = 1'b1;
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({tx, pop_out, busy, tx_done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_outputs: tx,pop,busy,done got %b expected 1000", {tx, pop_out, busy, tx_done});
        end
        checks++;
        if (tx_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", tx_count);
        end
        rst = 1'b1;
        exp_count = 0;
        step();
        checks++;
        if (pop_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_pop: got %b expected 1", pop_out);
        end
        p = cyc;
        repeat (L + 1) step();
        m = frame_mismatch_at(p, b);
        checks++;
        if (m !== -1) begin
            errors++;
            $display("FAIL reset_frame: byte %h mismatch at offset %0d expected none", b, m);
        end
        exp_count++;
        checks++;
        if (tx_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL reset_frame_count: got %0d expected %0d", tx_count, exp_count);
        end
    endtask

    task automatic test_single_byte();
        int w0, p, m, npop, ndone;
        w0 = cyc;
        push(8'hA5);
        wait_pop(p, 10);
        checks++;
        if (p < 0) begin
            errors++;
            $display("FAIL single_pop_seen: got none expected a pop within 10 cycles");
        end
        repeat (L + 1) step();
        npop = 0;
        ndone = 0;
        for (int i = w0; i < cyc; i++) begin
            npop += int'(pop_log[i]);
            ndone += int'(done_log[i]);
        end
        checks++;
        if (npop !== 1) begin
            errors++;
            $display("FAIL single_pop_count: got %0d expected 1", npop);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d expected 1", ndone);
        end
        m = frame_mismatch_at(p, 8'hA5);
        checks++;
        if (m !== -1) begin
            errors++;
            $display("FAIL single_frame_a5: mismatch at offset %0d expected none", m);
        end
        exp_count++;
        checks++;
        if (tx_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL single_count: got %0d expected %0d", tx_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes_q[$];
        int pops[$];
        int p0, m, n;
        en = 1'b0;
        step();
        bytes_q = '{8'h01, 8'h80, 8'hFF};
        for (int i = 0; i < 3; i++) bytes_q.push_back(8'($urandom));
        foreach (bytes_q[i]) push(bytes_q[i]);
        en = 1'b1;
        wait_pop(p0, 10);
        repeat (6 * (L + 1) + 5) step();
        if (p0 >= 0) begin
            for (int i = p0; i < cyc; i++) if (pop_log[i] === 1'b1) pops.push_back(i);
        end
        checks++;
        if (pops.size() !== 6) begin
            errors++;
            $display("FAIL b2b_pop_count: got %0d expected 6", pops.size());
        end
        n = (pops.size() < 6) ? pops.size() : 6;
        for (int i = 1; i < n; i++) begin
            checks++;
            if (pops[i] - pops[i-1] !== L + 1) begin
                errors++;
                $display("FAIL b2b_spacing: gap %0d got %0d cycles expected %0d", i, pops[i] - pops[i-1], L + 1);
            end
        end
        for (int i = 0; i < n; i++) begin
            m = frame_mismatch_at(pops[i], bytes_q[i]);
            checks++;
            if (m !== -1) begin
                errors++;
                $display("FAIL b2b_frame: byte %0d (%h) mismatch at offset %0d expected none", i, bytes_q[i], m);
            end
        end
        exp_count += 6;
        checks++;
        if (tx_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected %0d", tx_count, exp_count);
        end
    endtask

    task automatic test_empty_idle();
        int w0, npop, nlow, nbusy;
        en = 1'b1;
        w0 = cyc;
        repeat (100) step();
        npop = 0;
        nlow = 0;
        nbusy = 0;
        for (int i = w0; i < cyc; i++) begin
            npop += int'(pop_log[i]);
            nlow += int'(!tx_log[i]);
            nbusy += int'(busy_log[i]);
        end
        checks++;
        if (npop !== 0) begin
            errors++;
            $display("FAIL empty_no_pop: got %0d pops expected 0", npop);
        end
        checks++;
        if (nlow !== 0) begin
            errors++;
            $display("FAIL empty_tx_idle: got %0d low cycles expected 0", nlow);
        end
        checks++;
        if (nbusy !== 0) begin
            errors++;
            $display("FAIL empty_not_busy: got %0d busy cycles expected 0", nbusy);
        end
    endtask

    task automatic test_en_drop();
        logic [7:0] b1, b2;
        int p, p2, m, npop;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        push(b1);
        push(b2);
        en = 1'b1;
        wait_pop(p, 10);
        while (p >= 0 && cyc < p + 2 + 4 * C + 1) step();
        en = 1'b0;
        repeat (L + 60) step();
        m = frame_mismatch_at(p, b1);
        checks++;
        if (m !== -1) begin
            errors++;
            $display("FAIL endrop_frame: byte %h mismatch at offset %0d expected none", b1, m);
        end
        npop = 0;
        for (int i = p + 1; i < cyc; i++) if (i >= 0) npop += int'(pop_log[i]);
        checks++;
        if (npop !== 0) begin
            errors++;
            $display("FAIL endrop_no_pop: got %0d pops expected 0", npop);
        end
        exp_count++;
        checks++;
        if (tx_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL endrop_count: got %0d expected %0d", tx_count, exp_count);
        end
        en = 1'b1;
        wait_pop(p2, 10);
        repeat (L + 1) step();
        m = frame_mismatch_at(p2, b2);
        checks++;
        if (m !== -1) begin
            errors++;
            $display("FAIL endrop_resume_frame: byte %h mismatch at offset %0d expected none", b2, m);
        end
        exp_count++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b1, b2;
        int p, p2, m;
        b1 = 8'($urandom) & 8'hDF;
        b2 = 8'($urandom);
        push(b1);
        push(b2);
        en = 1'b1;
        wait_pop(p, 10);
        while (p >= 0 && cyc < p + 2 + 6 * C + 1) step();
        checks++;
        if ({tx, busy} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_pre: tx,busy got %b expected 01 in data bit 5", {tx, busy});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({tx, busy, pop_out, tx_done} !== 4'b1000 || tx_count !== 8'd0) begin
            errors++;
            $display("FAIL midrst_immediate: tx,busy,pop,done got %b count %0d expected 1000 count 0",
                     {tx, busy, pop_out, tx_done}, tx_count);
        end
        exp_count = 0;
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (pop_out !== 1'b1) begin
            errors++;
            $display("FAIL midrst_restart_pop: got %b expected 1", pop_out);
        end
        p2 = cyc;
        repeat (L + 1) step();
        m = frame_mismatch_at(p2, b2);
        checks++;
        if (m !== -1) begin
            errors++;
            $display("FAIL midrst_frame: byte %h mismatch at offset %0d expected none", b2, m);
        end
        exp_count++;
        checks++;
        if (tx_count !== 8'(exp_count)) begin
            errors++;
            $display("FAIL midrst_count: got %0d expected %0d", tx_count, exp_count);
        end
    endtask

    task automatic test_no_underrun();
        checks++;
        if (underruns !== 0) begin
            errors++;
            $display("FAIL no_underrun: got %0d pops on empty FIFO expected 0", underruns);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_empty_idle();
        test_en_drop();
        test_reset_mid_frame();
        test_no_underrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
